// File: rtl/jtkicker_snd_mbox_pkg.sv
// jtkicker_snd_mbox_pkg: shared encodings and sizing helpers for the sound mailbox.
package jtkicker_snd_mbox_pkg;
   localparam int IRQ_LEVEL = 0;
   localparam int IRQ_EDGE  = 1;

   // A single-entry FIFO still needs a 1-bit pointer variable; it is simply held at 0.
   function automatic int ptr_w(input int depth);
      return depth > 1 ? $clog2(depth) : 1;
   endfunction
endpackage

// File: rtl/jtkicker_mbox_fifo.sv
// jtkicker_mbox_fifo: command FIFO with occupancy count and a drop/overwrite policy when full.
module jtkicker_mbox_fifo
   import jtkicker_snd_mbox_pkg::*;
#(
   parameter int DW        = 8,
   parameter int DEPTH     = 4,
   parameter int OVERWRITE = 0,
   localparam int AW       = ptr_w(DEPTH),
   localparam int LW       = $clog2(DEPTH) + 1
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] din,
   input  logic          push,
   input  logic          pull,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level,
   output logic          ovf,
   output logic          acc
);
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp, wp1, rp1, wm1;
   logic [LW-1:0] nl;
   logic          pop, ovw;

   assign wp1 = DEPTH == 1 ? '0 : wp + 1'b1;
   assign rp1 = DEPTH == 1 ? '0 : rp + 1'b1;
   assign wm1 = DEPTH == 1 ? '0 : wp - 1'b1;
   assign pop = pull & ~empty;
   assign acc = push & (~full | pop);
   assign ovw = push & full & ~pop & (OVERWRITE != 0);
   assign nl  = level + LW'(acc) - LW'(pop);

   always_ff @(posedge clk) begin
      if (acc) mem[wp] <= din;
      else if (ovw) mem[wm1] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         level <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
         ovf   <= 1'b0;
         dout  <= '0;
      end else begin
         if (acc) wp <= wp1;
         if (pop) rp <= rp1;
         level <= nl;
         full  <= nl == LW'(DEPTH);
         empty <= nl == '0;
         ovf   <= (push & ~acc) | (ovf & ~pop);
         // The head register only changes when the new head is the incoming word or the next stored one;
         // popping the last entry leaves the popped value visible, like the old command latch.
         if ((acc & (empty | (pop & level == LW'(1)))) | (ovw & level == LW'(1))) dout <= din;
         else if (pop & level != LW'(1)) dout <= mem[rp1];
      end
   end
endmodule

// File: rtl/jtkicker_snd_mbox.sv
// jtkicker_snd_mbox: main-to-sound command FIFO, reply latch, sound CPU interrupt and timer.
module jtkicker_snd_mbox
   import jtkicker_snd_mbox_pkg::*;
#(
   parameter int DW        = 8,
   parameter int DEPTH     = 4,
   parameter int OVERWRITE = 0,
   parameter int IRQ_MODE  = IRQ_LEVEL,
   parameter int CNTW      = 11
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DW-1:0]            main_dout,
   input  logic                     m2s_wr,
   output logic                     m2s_full,
   output logic                     m2s_ovf,
   input  logic                     snd_rd,
   output logic [DW-1:0]            snd_dout,
   output logic                     snd_empty,
   output logic [$clog2(DEPTH):0]   snd_level,
   input  logic                     irq_ack,
   output logic                     int_n,
   input  logic                     cnt_cen,
   output logic [CNTW-1:0]          cnt,
   input  logic                     s2m_wr,
   input  logic [DW-1:0]            s2m_din,
   output logic [DW-1:0]            s2m_dout,
   output logic                     s2m_pend,
   input  logic                     s2m_rd
);
   logic acc, ack_l, ack_edge;

   assign ack_edge = irq_ack & ~ack_l;

   jtkicker_mbox_fifo #(.DW(DW), .DEPTH(DEPTH), .OVERWRITE(OVERWRITE)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (main_dout),
      .push  (m2s_wr),
      .pull  (snd_rd),
      .dout  (snd_dout),
      .full  (m2s_full),
      .empty (snd_empty),
      .level (snd_level),
      .ovf   (m2s_ovf),
      .acc   (acc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int_n    <= 1'b1;
         ack_l    <= 1'b0;
         cnt      <= '0;
         s2m_dout <= '0;
         s2m_pend <= 1'b0;
      end else begin
         ack_l    <= irq_ack;
         cnt      <= cnt + CNTW'(cnt_cen);
         s2m_pend <= s2m_wr | (s2m_pend & ~s2m_rd);
         if (s2m_wr) s2m_dout <= s2m_din;
         // Level mode follows the registered occupancy, so it trails the FIFO flags by one cycle.
         int_n <= IRQ_MODE == IRQ_EDGE ? (acc ? 1'b0 : ack_edge ? 1'b1 : int_n) : snd_level == '0;
      end
   end
endmodule

// File: doc/jtkicker_snd_mbox.md
# jtkicker_snd_mbox

Parametrised main-to-sound communication block for the sound board. It replaces the single command latch, the interrupt flip-flop and the free-running PSG-rate counter of earlier sound boards with one block containing:
- a command FIFO of configurable depth and width;
- a reply latch from the sound CPU back to the main CPU;
- a selectable-mode interrupt generator;
- a readable timer.

It sits between the main CPU bus and the sound Z80 address decoder.

## Interface
Parameters:
- DW, 8, command/reply data width
- DEPTH, 4, FIFO entries, power of two, 1..64
- OVERWRITE, 0, 1: a write when full replaces the newest entry; 0: the write is dropped
- IRQ_MODE, 0, 0: level, asserted while the FIFO is non-empty; 1: edge, set per accepted write and cleared by ack
- CNTW, 11, timer width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- main_dout  in  DW  command data from the main CPU
- m2s_wr  in  1  one-cycle command write strobe
- m2s_full  out  1  FIFO full
- m2s_ovf  out  1  sticky overflow flag (write lost or overwrote)
- snd_rd  in  1  one-cycle pop strobe from the sound CPU
- snd_dout  out  DW  FIFO head
- snd_empty  out  1  FIFO empty
- snd_level  out  $clog2(DEPTH)+1  current occupancy
- irq_ack  in  1  Z80 interrupt acknowledge (iorq & m1)
- int_n  out  1  interrupt to the sound CPU, active low
- cnt_cen  in  1  timer clock enable
- cnt  out  CNTW  free-running timer
- s2m_wr  in  1  sound CPU reply write strobe
- s2m_din  in  DW  reply data
- s2m_dout  out  DW  reply latch
- s2m_pend  out  1  reply written and not yet read
- s2m_rd  in  1  main CPU reply read strobe

## Operation
- FIFO: circular buffer with rd/wr pointers of $clog2(DEPTH) bits plus a separate occupancy count.
  - Pointers wrap at DEPTH.
  - DEPTH=1 uses the same logic with zero-width pointers removed.
- Accepted write: m2s_wr while not full, or while full with a simultaneous snd_rd. It stores the data, advances wr and increments the level.
- Write when full without a pop:
  - OVERWRITE=1: replaces the entry at wr-1 and sets m2s_ovf. The level is unchanged.
  - OVERWRITE=0: drops the data and sets m2s_ovf.
- Pop: snd_rd while non-empty advances rd and decrements the level. snd_rd while empty is ignored, with no pointer change.
- Simultaneous write and pop while non-empty: both pointers advance and the level is unchanged.
- Simultaneous write and pop while empty: the write is accepted and the pop is ignored, giving level 1.
- m2s_ovf clears on the first pop after it is set.
- snd_dout shows the head entry. When empty it holds the last popped value, so DEPTH=1 with OVERWRITE=1 behaves exactly as the legacy command latch.
- IRQ_MODE=0: int_n = registered ~(level!=0). irq_ack has no effect.
- IRQ_MODE=1: an irq flag is set on each accepted write and cleared on the irq_ack rising edge. If both occur in the same cycle, set wins.
- Timer: cnt increments on cnt_cen and wraps from all-ones to 0.
- Reply: s2m_wr loads s2m_dout and sets s2m_pend. s2m_rd clears s2m_pend. If both occur in the same cycle, the set wins.

## Timing
- Reset values: level 0, snd_empty 1, m2s_full 0, m2s_ovf 0, snd_dout 0, int_n 1, cnt 0, s2m_dout 0, s2m_pend 0. FIFO memory contents are undefined.
- All flags and outputs are registered.
- After a write at edge N, snd_empty falls, the level updates and snd_dout is valid at edge N+1.
- int_n falls at N+1 in IRQ_MODE=1. In IRQ_MODE=0 it falls at N+2 (derived from the registered level).
- After a pop at edge N, the next head is on snd_dout at N+1.
- irq_ack edge detection uses one register. int_n rises one cycle after the ack edge is detected.
- Reset asserted mid-operation clears everything immediately and asynchronously. No write or pop in flight survives.

## Structure
- Shared package holds the IRQ_MODE encodings (IRQ_LEVEL=0, IRQ_EDGE=1) and the pointer-width function.
- One natural sub-module: jtkicker_mbox_fifo (storage, pointers, level, overwrite policy). The IRQ, timer and reply logic stay in the top level.

## Test plan
- DEPTH=4, OVERWRITE=0: write 11,22,33,44,55 → m2s_full=1 after the 4th write, m2s_ovf=1, 55 dropped; pops return 11,22,33,44; snd_empty=1; m2s_ovf cleared after the first pop.
- DEPTH=1, OVERWRITE=1: write 5A then A5 with no pop → snd_dout=A5, level=1, m2s_ovf=1.
- Full FIFO, simultaneous write 77 and pop → level stays 4, 77 read last. Empty FIFO, simultaneous write 09 and pop → level=1, head=09.
- IRQ_MODE=1: write, then irq_ack in the same cycle as a second write → int_n stays 0; a lone ack → int_n=1. IRQ_MODE=0: int_n=0 until the last pop, then 1.
- CNTW=4: 16 cnt_cen pulses → cnt returns to 0. Stalled cnt_cen → cnt holds.
- s2m_wr 3C, then s2m_rd → s2m_pend 1 then 0, s2m_dout stays 3C. Assert rst_n low mid-burst → all outputs at reset values within the same cycle.
